hex_display_scheduler: RTL and testbench



---
 rtl/hex_display_scheduler_if.sv | 39 +++
 rtl/hex_display_scheduler.sv | 133 +++++++++++++
 tb/tb_hex_display_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scheduler_if.sv
// Display scheduler bus: primary value, message
// channel, display controls and digit drive.
interface hex_display_scheduler_if #(
  parameter int BRIGHT_W = 3
);
  logic [15:0]         data_a;
  logic                b_valid;
  logic [15:0]         b_data;
  logic                b_ready;
  logic                busy;
  logic                blank_lz;
  logic [BRIGHT_W-1:0] brightness;
  logic [3:0]          anodes;
  logic [3:0]          nibble;

  modport master (
    output data_a,
    output b_valid,
    output b_data,
    output blank_lz,
    output brightness,
    input  b_ready,
    input  busy,
    input  anodes,
    input  nibble
  );

  modport slave (
    input  data_a,
    input  b_valid,
    input  b_data,
    input  blank_lz,
    input  brightness,
    output b_ready,
    output busy,
    output anodes,
    output nibble
  );
endinterface

// File: rtl/hex_display_scheduler.sv
// 4-digit hex scan controller: frame-latched data,
// one-shot message overlay, blanking and PWM dimming.
module hex_display_scheduler #(
  parameter int CLK_DIV     = 1000,
  parameter int BRIGHT_W    = 3,
  parameter int SHOW_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  hex_display_scheduler_if.slave  bus
);

  localparam int PS_W = $clog2(CLK_DIV);
  localparam int FL_W = $clog2(SHOW_FRAMES + 1);

  typedef enum logic [1:0] {
    SHOW_A,
    WAIT_B,
    SHOW_B
  } state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [1:0]          i_q, i_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [15:0]         frame_q, frame_d;
  logic [15:0]         buf_q, buf_d;
  logic [FL_W-1:0]     left_q, left_d;
  logic [3:0]          anodes_q, anodes_d;
  logic [3:0]          nibble_q, nibble_d;

  logic       tick;
  logic       frame_end;
  logic       lit;
  logic [3:0] blank;
  logic       accept;

  assign tick      = (ps_q == PS_W'(CLK_DIV - 1));
  assign frame_end = tick && (i_q == 2'd3);

  assign bus.b_ready = !rst && (state_q == SHOW_A);
  assign bus.busy    = (state_q != SHOW_A);
  assign bus.anodes  = anodes_q;
  assign bus.nibble  = nibble_q;

  assign accept = bus.b_valid && bus.b_ready;

  // Scan timing and PWM counters advance every clock.
  always_comb begin
    ps_d  = tick ? '0 : ps_q + 1'b1;
    i_d   = tick ? i_q + 2'd1 : i_q;
    pwm_d = pwm_q + 1'b1;
  end

  // Digit k is dark when it and every higher digit are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[1] = bus.blank_lz && (frame_q[15:4] == 12'h000);
    blank[2] = bus.blank_lz && (frame_q[15:8] == 8'h00);
    blank[3] = bus.blank_lz && (frame_q[15:12] == 4'h0);
  end

  // Next digit drive; nibble follows the slot even when dark.
  always_comb begin
    lit      = (&bus.brightness) || (pwm_q < bus.brightness);
    anodes_d = (lit && !blank[i_q]) ? (4'b0001 << i_q) : 4'b0000;
    nibble_d = frame_q[{i_q, 2'b00} +: 4];
  end

  // Source arbitration; frame data changes only at frame_end.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    buf_d   = buf_q;
    left_d  = left_q;
    unique case (state_q)
      SHOW_A: begin
        if (accept) begin
          buf_d   = bus.b_data;
          state_d = WAIT_B;
        end
        if (frame_end) begin
          frame_d = bus.data_a;
        end
      end
      WAIT_B: begin
        if (frame_end) begin
          frame_d = buf_q;
          left_d  = FL_W'(SHOW_FRAMES);
          state_d = SHOW_B;
        end
      end
      SHOW_B: begin
        if (frame_end) begin
          left_d = left_q - 1'b1;
          if (left_q == FL_W'(1)) begin
            frame_d = bus.data_a;
            state_d = SHOW_A;
          end
        end
      end
      default: begin
        state_d = SHOW_A;
      end
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SHOW_A;
      ps_q     <= '0;
      i_q      <= 2'd0;
      pwm_q    <= '0;
      frame_q  <= 16'h0000;
      buf_q    <= 16'h0000;
      left_q   <= '0;
      anodes_q <= 4'b0000;
      nibble_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      ps_q     <= ps_d;
      i_q      <= i_d;
      pwm_q    <= pwm_d;
      frame_q  <= frame_d;
      buf_q    <= buf_d;
      left_q   <= left_d;
      anodes_q <= anodes_d;
      nibble_q <= nibble_d;
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: table vectors,
// directed message/reset sequences, random vs model.
module tb_hex_display_scheduler;

  localparam int CD = 4;
  localparam int BW = 2;
  localparam int SF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hex_display_scheduler_if #(.BRIGHT_W(BW)) bus ();

  hex_display_scheduler #(
    .CLK_DIV    (CD),
    .BRIGHT_W   (BW),
    .SHOW_FRAMES(SF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          d_rst;
  logic [15:0]   d_a;
  logic          d_bv;
  logic [15:0]   d_bd;
  logic          d_lz;
  logic [BW-1:0] d_br;

  int          mt;
  int          last_t;
  logic [15:0] m_show;
  logic [15:0] m_pend[$];
  int          m_left;

  logic [3:0] e_an;
  logic [3:0] e_nib;
  logic       e_rdy;
  logic       e_busy;

  typedef struct packed {
    logic [15:0]     a;
    logic            lz;
    logic [1:0]      br;
    logic [3:0][2:0] on;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h",
               nm, last_t, act, exp);
    end
  endtask

  // One clock: drive at negedge, model the edge,
  // compare all outputs just after posedge.
  task automatic step();
    int  ph;
    int  dg;
    int  pwm;
    bit  lit;
    bit  blk;
    bit  fe;
    bit  idle;
    @(negedge clk);
    rst            = d_rst;
    bus.data_a     = d_a;
    bus.b_valid    = d_bv;
    bus.b_data     = d_bd;
    bus.blank_lz   = d_lz;
    bus.brightness = d_br;
    if (d_rst) begin
      e_an   = 4'h0;
      e_nib  = 4'h0;
      mt     = 0;
      m_show = 16'h0000;
      m_pend.delete();
      m_left = 0;
      last_t = -1;
    end else begin
      ph  = mt % CD;
      dg  = (mt / CD) % 4;
      pwm = mt % (1 << BW);
      lit = (int'(d_br) == (1 << BW) - 1) ||
            (pwm < int'(d_br));
      blk = d_lz && (dg > 0) &&
            ((m_show >> (4 * dg)) == 16'h0);
      e_an  = (lit && !blk) ? 4'(1 << dg) : 4'h0;
      e_nib = m_show[4*dg +: 4];
      idle  = (m_pend.size() == 0) && (m_left == 0);
      fe    = (ph == CD - 1) && (dg == 3);
      if (fe) begin
        if (m_left > 0) begin
          if (m_left == 1) m_show = d_a;
          m_left--;
        end else if (m_pend.size() > 0) begin
          m_show = m_pend.pop_front();
          m_left = SF;
        end else begin
          m_show = d_a;
        end
      end
      if (idle && d_bv) m_pend.push_back(d_bd);
      last_t = mt;
      mt++;
    end
    idle   = (m_pend.size() == 0) && (m_left == 0);
    e_busy = !idle;
    e_rdy  = !d_rst && idle;
    @(posedge clk);
    #1;
    chk("anodes", bus.anodes, e_an);
    chk("nibble", bus.nibble, e_nib);
    chk("b_ready", bus.b_ready, e_rdy);
    chk("busy", bus.busy, e_busy);
  endtask

  task automatic do_reset(int n);
    d_rst = 1'b1;
    for (int k = 0; k < n; k++) step();
    chk("rst_anodes", bus.anodes, 0);
    chk("rst_nibble", bus.nibble, 0);
    chk("rst_ready", bus.b_ready, 0);
    chk("rst_busy", bus.busy, 0);
    d_rst = 1'b0;
  endtask

  initial begin
    int cnt[4];
    int dg;

    tbl[0] = '{16'h1234, 1'b0, 2'd3, {3'd4, 3'd4, 3'd4, 3'd4}};
    tbl[1] = '{16'h0050, 1'b1, 2'd3, {3'd0, 3'd0, 3'd4, 3'd4}};
    tbl[2] = '{16'h0000, 1'b1, 2'd3, {3'd0, 3'd0, 3'd0, 3'd4}};
    tbl[3] = '{16'h1234, 1'b0, 2'd0, {3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[4] = '{16'h1234, 1'b0, 2'd1, {3'd1, 3'd1, 3'd1, 3'd1}};
    tbl[5] = '{16'h1234, 1'b0, 2'd2, {3'd2, 3'd2, 3'd2, 3'd2}};
    tbl[6] = '{16'h0F00, 1'b1, 2'd3, {3'd0, 3'd4, 3'd4, 3'd4}};

    d_rst = 1'b1;
    d_a   = 16'h0000;
    d_bv  = 1'b0;
    d_bd  = 16'h0000;
    d_lz  = 1'b0;
    d_br  = 2'd3;
    bus.data_a     = 16'h0000;
    bus.b_valid    = 1'b0;
    bus.b_data     = 16'h0000;
    bus.blank_lz   = 1'b0;
    bus.brightness = 2'd3;
    mt     = 0;
    last_t = -1;
    m_show = 16'h0000;
    m_left = 0;

    // Static patterns: count lit clocks per digit in frame 3.
    for (int n = 0; n < 7; n++) begin
      d_a  = tbl[n].a;
      d_lz = tbl[n].lz;
      d_br = tbl[n].br;
      do_reset(2);
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int k = 0; k < 48; k++) begin
        step();
        if (last_t >= 32) begin
          dg = (last_t - 32) / CD;
          if (bus.anodes == 4'(1 << dg)) cnt[dg]++;
          if (last_t % CD == 0)
            chk($sformatf("tbl%0d_nib%0d", n, dg),
                bus.nibble, tbl[n].a[4*dg +: 4]);
        end
      end
      for (int k = 0; k < 4; k++)
        chk($sformatf("tbl%0d_on%0d", n, k),
            cnt[k], tbl[n].on[k]);
    end

    // Message overlay, ignored request, mid-frame change.
    d_a  = 16'h1234;
    d_lz = 1'b0;
    d_br = 2'd3;
    do_reset(2);
    while (mt < 130) begin
      d_bv = (mt == 20) || (mt == 40) || (mt == 120);
      d_bd = (mt == 20)  ? 16'hBEEF :
             (mt == 120) ? 16'h5555 : 16'h1111;
      if (mt == 100) d_a = 16'hABCD;
      step();
      d_bv = 1'b0;
      case (last_t)
        19: chk("pre_ready", bus.b_ready, 1);
        20: begin
          chk("acc_ready", bus.b_ready, 0);
          chk("acc_busy", bus.busy, 1);
        end
        31: chk("wait_nib", bus.nibble, 4'h1);
        32: chk("beef_d0", bus.nibble, 4'hF);
        36: chk("beef_d1", bus.nibble, 4'hE);
        40: chk("beef_d2", bus.nibble, 4'hE);
        44: begin
          chk("beef_d3", bus.nibble, 4'hB);
          chk("beef_an3", bus.anodes, 4'b1000);
        end
        48: chk("beef2_d0", bus.nibble, 4'hF);
        62: chk("show_busy", bus.busy, 1);
        63: begin
          chk("ret_busy", bus.busy, 0);
          chk("ret_ready", bus.b_ready, 1);
        end
        64: chk("ret_d0", bus.nibble, 4'h4);
        80: chk("noacc_d0", bus.nibble, 4'h4);
        104: chk("mid_d2", bus.nibble, 4'h2);
        108: chk("mid_d3", bus.nibble, 4'h1);
        112: chk("new_d0", bus.nibble, 4'hD);
        128: chk("b2_d0", bus.nibble, 4'h5);
        default: ;
      endcase
    end

    // Reset during the message aborts it.
    do_reset(2);
    for (int k = 0; k < 32; k++) begin
      step();
      case (last_t)
        0: begin
          chk("ab_busy", bus.busy, 0);
          chk("ab_ready", bus.b_ready, 1);
          chk("ab_d0", bus.nibble, 4'h0);
        end
        12: chk("ab_d3", bus.nibble, 4'h0);
        16: chk("ab_new_d0", bus.nibble, 4'hD);
        20: chk("ab_new_d1", bus.nibble, 4'hC);
        default: ;
      endcase
    end

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      d_rst = ($urandom_range(0, 399) == 0);
      d_bv  = ($urandom_range(0, 9) == 0);
      d_bd  = 16'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        d_a = ($urandom_range(0, 3) == 0) ?
              16'($urandom_range(0, 255)) : 16'($urandom);
      end
      if ($urandom_range(0, 49) == 0)
        d_lz = 1'($urandom);
      if ($urandom_range(0, 49) == 0)
        d_br = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
